// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Brief    : Buffers FPU commands in a FIFO and issues them one at a time,
//            reporting completion or a BUSY-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_op,
   input  logic [4:0]  cmd_x1,
   input  logic [4:0]  cmd_x2,
   input  logic [4:0]  cmd_y,
   input  logic [31:0] cmd_data,
   output logic [5:0]  operation,
   output logic [4:0]  x1,
   output logic [4:0]  x2,
   output logic [4:0]  y,
   output logic [31:0] in_data,
   output logic        fpu_ready,
   input  logic        fpu_valid,
   input  logic        fpu_cond,
   input  logic [31:0] fpu_out_data,
   output logic        done,
   output logic        done_cond,
   output logic [31:0] done_data,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] issued_cnt
);

   localparam int          C_AW      = $clog2(DEPTH);
   localparam int          C_W       = 53;
   localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   logic [C_W-1:0]    r_mem [DEPTH];
   logic [C_AW-1:0]   r_wr_ptr;
   logic [C_AW-1:0]   r_rd_ptr;
   logic [C_AW:0]     r_count;
   logic [C_W-1:0]    r_cmd;
   logic              r_fpu_ready;
   logic [15:0]       r_tmo;
   logic              r_done;
   logic              r_done_cond;
   logic [31:0]       r_done_data;
   logic              r_err;
   logic [15:0]       r_issued;

   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   // DEPTH is a power of two, so the count MSB alone marks a full FIFO
   assign w_full    = r_count[C_AW];
   assign w_empty   = (r_count == '0);
   assign cmd_ready = ~w_full;
   assign w_push    = cmd_valid & ~w_full;
   assign w_pop     = (r_state == S_IDLE) & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_cmd       <= '0;
         r_fpu_ready <= 1'b0;
         r_tmo       <= '0;
         r_done      <= 1'b0;
         r_done_cond <= 1'b0;
         r_done_data <= '0;
         r_err       <= 1'b0;
         r_issued    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_cmd       <= r_mem[r_rd_ptr];
                  r_fpu_ready <= 1'b1;
                  r_tmo       <= 16'd1;
                  r_issued    <= r_issued + 16'd1;
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               // completion wins over a timeout landing on the same edge
               if (fpu_valid) begin
                  r_cmd       <= '0;
                  r_fpu_ready <= 1'b0;
                  r_tmo       <= '0;
                  r_done      <= 1'b1;
                  r_done_cond <= fpu_cond;
                  r_done_data <= fpu_out_data;
                  r_state     <= S_GAP;
               end else if (r_tmo >= C_TIMEOUT) begin
                  r_cmd       <= '0;
                  r_fpu_ready <= 1'b0;
                  r_tmo       <= '0;
                  r_err       <= 1'b1;
                  r_state     <= S_GAP;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            S_GAP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd       <= '0;
               r_fpu_ready <= 1'b0;
               r_tmo       <= '0;
            end
         endcase
      end
   end

   assign {operation, x1, x2, y, in_data} = r_cmd;
   assign fpu_ready   = r_fpu_ready;
   assign done        = r_done;
   assign done_cond   = r_done_cond;
   assign done_data   = r_done_data;
   assign err_timeout = r_err;
   assign issued_cnt  = r_issued;
   assign busy        = (r_state != S_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL accept parameter DEPTH, default 4, meaning command FIFO entries (power of 2, 2..16).
REQ-002 SHALL accept parameter TIMEOUT, default 255, meaning maximum cycles in BUSY without fpu_valid before abort (1..65535).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: upstream command handshake.
REQ-006 SHALL have ports cmd_op in 6, cmd_x1 in 5, cmd_x2 in 5, cmd_y in 5, cmd_data in 32: command fields, opaque (`FPU_OP* encodings); no decoding.
REQ-007 SHALL have ports operation out 6, x1 out 5, x2 out 5, y out 5, in_data out 32: FPU command fields.
REQ-008 SHALL have ports fpu_ready out 1 (command present), fpu_valid in 1 (FPU completion), fpu_cond in 1, fpu_out_data in 32.
REQ-009 SHALL have ports done out 1, done_cond out 1, done_data out 32: completion report.
REQ-010 SHALL have ports busy out 1, err_timeout out 1, issued_cnt out 16.

Function
REQ-011 SHALL buffer commands in a DEPTH-entry FIFO; push on cmd_valid & cmd_ready.
REQ-012 SHALL drive cmd_ready = FIFO not full, registered-state only; no combinational path from fpu_valid or cmd_valid.
REQ-013 SHALL, when full, deassert cmd_ready even if a pop occurs the same cycle.
REQ-014 SHALL implement states IDLE, BUSY, GAP.
REQ-015 SHALL, in IDLE with FIFO non-empty at edge N, pop the head, load it onto operation/x1/x2/y/in_data, set fpu_ready=1, enter BUSY, all visible after edge N.
REQ-016 SHALL give a command pushed into an empty FIFO at edge N an fpu_ready rise after edge N+1 (1-cycle issue latency).
REQ-017 SHALL hold fpu_ready and all command fields stable for the whole of BUSY.
REQ-018 SHALL, on fpu_valid=1 sampled in BUSY at edge M, clear fpu_ready, pulse done for exactly one cycle, register done_cond=fpu_cond and done_data=fpu_out_data, and enter GAP.
REQ-019 SHALL leave GAP for IDLE unconditionally after one cycle; next issue is earliest at edge M+2 (fpu_ready low for at least 2 cycles between commands).
REQ-020 SHALL drive command fields to zero whenever fpu_ready=0.
REQ-021 SHALL ignore fpu_valid in IDLE and GAP: no done, no state change.
REQ-022 SHALL count BUSY cycles from 1; if count reaches TIMEOUT with no fpu_valid, clear fpu_ready, set err_timeout, suppress done, and enter GAP.
REQ-023 SHALL give fpu_valid priority over timeout on the same edge.
REQ-024 SHALL keep err_timeout sticky until reset; operation continues with later commands.
REQ-025 SHALL increment issued_cnt on every IDLE->BUSY transition, wrapping 0xFFFF->0x0000.
REQ-026 SHALL drive busy = (state != IDLE) or FIFO non-empty.
REQ-027 SHALL hold done_cond/done_data at their last captured values between done pulses.

Reset
REQ-028 SHALL, on rstn low, asynchronously force state IDLE, FIFO empty, cmd_ready=1, fpu_ready=0, all command fields 0, done=0, done_cond=0, done_data=0, busy=0, err_timeout=0, issued_cnt=0, timeout counter 0.
REQ-029 SHALL discard queued and in-flight commands on reset mid-BUSY; no done is produced for the aborted command.
REQ-030 SHALL accept the first command at the first posedge after rstn deasserts.

Verification
REQ-031 SHALL pass this scenario: push `FPU_OPSET y=1 data=0x3f800000; FPU model gives valid 1 cycle after ready -> fpu_ready high 1 cycle after push, done pulse 1 cycle, issued_cnt=1, busy=0 two cycles later.
REQ-032 SHALL pass this scenario: push 5 commands back-to-back with FPU valid latency 3 -> cmd_ready low after 4th push if none issued, 5th accepted after first pop, 5 done pulses in order, done_data matches model outputs.
REQ-033 SHALL pass this scenario: `FPU_OPFMUL x1=0 x2=1 y=2, model returns out_data=0x3fd9999a cond=1 -> done_data=0x3fd9999a, done_cond=1, fields stable through BUSY.
REQ-034 SHALL pass this scenario: FPU never asserts valid, TIMEOUT=255 -> fpu_ready drops after 255 BUSY cycles, err_timeout=1, no done, next queued command issues normally.
REQ-035 SHALL pass this scenario: fpu_valid pulsed in IDLE, and rstn pulsed low mid-BUSY with 2 queued -> no done, all outputs at reset values, FIFO empty.
REQ-036 SHALL pass this scenario: 65536 issued commands -> issued_cnt wraps to 0x0000.
